// File: rtl/obstacle_alert_arbiter.sv
// N-channel obstacle alert arbiter: per-channel debounce, fixed-priority selection,
// timed alert with tone, optional preemption/retrigger and a post-alert cooldown.
module obstacle_alert_arbiter #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int COOL_CYCLES     = 0,
  parameter int TONE_HALF       = 50000,
  localparam int IDX_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [N_CH-1:0]   sensor_in,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              preempt_en,
  input  logic              retrigger_en,
  output logic [N_CH-1:0]   speaker_out,
  output logic              tone_out,
  output logic              active,
  output logic [IDX_W-1:0]  active_idx,
  output logic [7:0]        event_cnt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int COOL_W = (COOL_CYCLES > 0) ? $clog2(COOL_CYCLES + 1) : 1;
  localparam int TONE_W = $clog2(TONE_HALF + 1);

  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'((COOL_CYCLES > 0) ? COOL_CYCLES - 1 : 0);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ALERT    = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;

  logic [N_CH-1:0][DB_W-1:0] db_q, db_d;
  logic [N_CH-1:0]           qual;
  logic                      any_qual;
  logic [IDX_W-1:0]          first_idx;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;
  logic [7:0]        evt_q, evt_d;
  logic [N_CH-1:0]   speaker_q, speaker_d;
  logic              active_q, active_d;
  logic              tone_wrap;

  // Qualification is decoded from the registered counter, so it lags the input by one edge.
  always_comb begin
    db_d = db_q;
    qual = '0;
    for (int i = 0; i < N_CH; i++) begin
      qual[i] = (db_q[i] == DB_MAX);
      if (sensor_in[i] && !ch_mask[i]) begin
        db_d[i] = qual[i] ? DB_MAX : db_q[i] + 1'b1;
      end else begin
        db_d[i] = '0;
      end
    end
  end

  always_comb begin
    any_qual  = 1'b0;
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (qual[i]) begin
        any_qual  = 1'b1;
        first_idx = IDX_W'(i);
      end
    end
  end

  assign tone_wrap = (tone_cnt_q == TONE_LAST);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    cool_d     = cool_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    evt_d      = evt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_qual) begin
          state_d    = ST_ALERT;
          idx_d      = first_idx;
          hold_d     = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
          evt_d      = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;
        end
      end
      ST_ALERT: begin
        if (preempt_en && any_qual && (first_idx < idx_q)) begin
          idx_d      = first_idx;
          hold_d     = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
          evt_d      = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;
        end else if (retrigger_en && qual[idx_q]) begin
          hold_d     = '0;
          tone_cnt_d = tone_wrap ? '0 : tone_cnt_q + 1'b1;
          tone_d     = tone_q ^ tone_wrap;
        end else if (hold_q == HOLD_LAST) begin
          state_d    = (COOL_CYCLES > 0) ? ST_COOLDOWN : ST_IDLE;
          idx_d      = '0;
          hold_d     = '0;
          cool_d     = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
        end else begin
          hold_d     = hold_q + 1'b1;
          tone_cnt_d = tone_wrap ? '0 : tone_cnt_q + 1'b1;
          tone_d     = tone_q ^ tone_wrap;
        end
      end
      ST_COOLDOWN: begin
        if (cool_q == COOL_LAST) begin
          state_d = ST_IDLE;
          cool_d  = '0;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    speaker_d = '0;
    active_d  = (state_d == ST_ALERT);
    if (active_d) begin
      speaker_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q       <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      cool_q     <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      evt_q      <= '0;
      speaker_q  <= '0;
      active_q   <= 1'b0;
    end else if (ena) begin
      db_q       <= db_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      cool_q     <= cool_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      evt_q      <= evt_d;
      speaker_q  <= speaker_d;
      active_q   <= active_d;
    end
  end

  assign speaker_out = speaker_q;
  assign tone_out    = tone_q;
  assign active      = active_q;
  assign active_idx  = idx_q;
  assign event_cnt   = evt_q;

endmodule

// File: tb/tb_obstacle_alert_arbiter.sv
// Directed and randomized bench for obstacle_alert_arbiter, compared every edge against
// an abstract model built from run lengths, remaining hold time and alert age.
module tb_obstacle_alert_arbiter;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int H  = 10;
  localparam int C  = 3;
  localparam int TH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic [N-1:0] sensor_in = '0;
  logic [N-1:0] ch_mask = '0;
  logic         preempt_en = 1'b0;
  logic         retrigger_en = 1'b0;
  logic [N-1:0] speaker_out;
  logic         tone_out;
  logic         active;
  logic [1:0]   active_idx;
  logic [7:0]   event_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 idle, 1 alert, 2 cooldown.
  int m_run[N];
  int m_mode, m_idx, m_rem, m_age, m_crem, m_evc;

  obstacle_alert_arbiter #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .COOL_CYCLES(C), .TONE_HALF(TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sensor_in), .ch_mask(ch_mask),
    .preempt_en(preempt_en), .retrigger_en(retrigger_en), .speaker_out(speaker_out),
    .tone_out(tone_out), .active(active), .active_idx(active_idx), .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_mode = 0; m_idx = 0; m_rem = 0; m_age = 0; m_crem = 0; m_evc = 0;
  endtask

  task automatic model_bump();
    if (m_evc < 255) m_evc++;
  endtask

  task automatic model_step();
    bit q[N];
    int low;
    if (!ena) return;
    low = -1;
    for (int i = N - 1; i >= 0; i--) begin
      q[i] = (m_run[i] >= D);
      if (q[i]) low = i;
    end
    case (m_mode)
      0: if (low >= 0) begin
        m_mode = 1; m_idx = low; m_rem = H - 1; m_age = 0; model_bump();
      end
      1: begin
        if (preempt_en && low >= 0 && low < m_idx) begin
          m_idx = low; m_rem = H - 1; m_age = 0; model_bump();
        end else if (retrigger_en && q[m_idx]) begin
          m_rem = H - 1; m_age++;
        end else if (m_rem == 0) begin
          m_mode = (C > 0) ? 2 : 0; m_crem = C - 1; m_idx = 0; m_age = 0;
        end else begin
          m_rem--; m_age++;
        end
      end
      default: if (m_crem == 0) m_mode = 0; else m_crem--;
    endcase
    for (int i = 0; i < N; i++)
      m_run[i] = (sensor_in[i] && !ch_mask[i]) ? m_run[i] + 1 : 0;
  endtask

  task automatic check_all();
    int on;
    on = (m_mode == 1) ? 1 : 0;
    check("active", 8'(active), 8'(on));
    check("speaker", 8'(speaker_out), on ? 8'(1 << m_idx) : 8'd0);
    check("idx", 8'(active_idx), on ? 8'(m_idx) : 8'd0);
    check("tone", 8'(tone_out), on ? 8'((m_age / TH) % 2) : 8'd0);
    check("event_cnt", event_cnt, 8'(m_evc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic tick_n(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    check("rst_event", event_cnt, 8'd0);
    rst_n = 1'b1;
    ena = 1'b1;

    // Single channel alert timing and tone.
    sensor_in = 3'b010;
    tick_n(4);
    check("t2_not_yet", 8'(active), 8'd0);
    tick();
    check("t2_spk", 8'(speaker_out), 8'b010);
    check("t2_idx", 8'(active_idx), 8'd1);
    check("t2_evt", event_cnt, 8'd1);
    tick_n(2);
    check("t2_tone_rise", 8'(tone_out), 8'd1);
    tick_n(7);
    check("t2_still_on", 8'(active), 8'd1);
    tick();
    check("t2_cleared", 8'(speaker_out), 8'd0);
    sensor_in = '0;
    tick_n(6);

    // Asynchronous reset in the middle of an alert.
    sensor_in = 3'b010;
    tick_n(7);
    check("t1_on", 8'(active), 8'd1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("t1_rst_spk", 8'(speaker_out), 8'd0);
    #1 rst_n = 1'b1;
    tick_n(4);
    check("t1_wait", 8'(active), 8'd0);
    tick();
    check("t1_realert", 8'(active), 8'd1);
    sensor_in = '0;
    tick_n(16);

    // Glitch rejection, then a clean 4-edge hold.
    sensor_in = 3'b001; tick_n(3);
    sensor_in = 3'b000; tick();
    sensor_in = 3'b001; tick_n(3);
    sensor_in = 3'b000; tick_n(3);
    check("t3_glitch", 8'(active), 8'd0);
    sensor_in = 3'b001; tick_n(4);
    sensor_in = 3'b000; tick();
    check("t3_alert", 8'(speaker_out), 8'b001);
    tick_n(16);

    // Preemption at hold=5.
    preempt_en = 1'b1;
    sensor_in = 3'b100; tick_n(5);
    check("t4_ch2", 8'(speaker_out), 8'b100);
    tick();
    sensor_in = 3'b101; tick_n(4);
    tick();
    check("t4_preempt_spk", 8'(speaker_out), 8'b001);
    check("t4_preempt_evt", event_cnt, 8'd4);
    sensor_in = 3'b000;
    tick_n(9);
    check("t4_hold_restart", 8'(active), 8'd1);
    tick();
    check("t4_expired", 8'(active), 8'd0);
    tick_n(5);

    // Same scenario without preemption.
    preempt_en = 1'b0;
    sensor_in = 3'b100; tick_n(5);
    tick();
    sensor_in = 3'b101; tick_n(8);
    check("t4b_keep", 8'(speaker_out), 8'b100);
    tick();
    check("t4b_end", 8'(active), 8'd0);
    tick_n(3);
    check("t4b_cool", 8'(active), 8'd0);
    tick();
    check("t4b_after_cool", 8'(speaker_out), 8'b001);
    sensor_in = '0;
    tick_n(16);

    // Retrigger keeps the alert alive.
    retrigger_en = 1'b1;
    sensor_in = 3'b010;
    tick_n(45);
    check("t5_held", 8'(active_idx), 8'd1);
    retrigger_en = 1'b0;
    tick_n(9);
    check("t5_last", 8'(active), 8'd1);
    tick();
    check("t5_expire", 8'(active), 8'd0);
    tick_n(3);
    tick();
    check("t5_realert", 8'(active), 8'd1);
    sensor_in = '0;
    tick_n(16);

    // Clock enable freeze mid-alert.
    sensor_in = 3'b001;
    tick_n(8);
    ena = 1'b0;
    tick_n(20);
    check("t6_frozen", 8'(active), 8'd1);
    sensor_in = '0;
    ena = 1'b1;
    tick_n(6);
    check("t6_resume", 8'(active), 8'd1);
    tick();
    check("t6_end", 8'(active), 8'd0);
    tick_n(4);

    // Full mask blocks everything.
    ch_mask = 3'b111;
    for (int i = 0; i < 50; i++) begin
      sensor_in = 3'($urandom_range(0, 7));
      tick();
    end
    check("t6_masked", 8'(active), 8'd0);
    ch_mask = '0;

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) sensor_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) ch_mask = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 20) == 0) preempt_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 20) == 0) retrigger_en = 1'($urandom_range(0, 1));
      ena = ($urandom_range(0, 9) != 0);
      tick();
    end

    // Event counter saturation.
    ena = 1'b1; ch_mask = '0; preempt_en = 1'b0; retrigger_en = 1'b0;
    sensor_in = 3'b001;
    tick_n(14 * 260);
    check("sat_event", event_cnt, 8'd255);
    tick_n(30);
    check("sat_hold", event_cnt, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
